// File: rtl/data_ram_arbiter.sv
// Arbitrates the single-port data RAM between the CPU and a host/loader port.
// Optional grant statistics are enabled by defining ARB_STATS_EN.
module data_ram_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int RD_LAT         = 1,
  parameter int HOST_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
`ifdef ARB_STATS_EN
  input  logic              stat_clr,
  output logic [15:0]       stat_cpu_grant,
  output logic [15:0]       stat_host_grant,
  output logic [15:0]       stat_conflict,
`endif
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int BW = $clog2(HOST_BURST_MAX + 1);
  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(HOST_BURST_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_e;
  typedef enum logic {GRANT_CPU, GRANT_HOST} grant_e;

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              cpu_ack_q, cpu_ack_d, host_ack_q, host_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, host_rdata_q, host_rdata_d;
  logic              grant_host;

  // Host wins when alone, right after a CPU grant, or while its burst allowance lasts.
  assign grant_host = host_req & (~cpu_req | (last_grant_q == GRANT_CPU) |
                                  (burst_cnt_q < BURST_MAX));

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req | host_req) begin
          state_d = S_ACCESS;
          if (grant_host) begin
            last_grant_d = GRANT_HOST;
            ram_we_d     = host_we;
            ram_addr_d   = host_addr;
            ram_din_d    = host_wdata;
            if (burst_cnt_q != BURST_MAX) burst_cnt_d = burst_cnt_q + 1'b1;
          end else begin
            last_grant_d = GRANT_CPU;
            ram_we_d     = cpu_we;
            ram_addr_d   = cpu_addr;
            ram_din_d    = cpu_wdata;
            burst_cnt_d  = '0;
          end
        end
      end
      S_ACCESS: begin
        if (ram_we_q) begin
          state_d    = S_DONE;
          cpu_ack_d  = (last_grant_q == GRANT_CPU);
          host_ack_d = (last_grant_q == GRANT_HOST);
        end else begin
          state_d    = S_WAIT;
          wait_cnt_d = WW'(RD_LAT - 1);
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          // Last latency edge: the RAM output belongs to the current owner.
          state_d = S_DONE;
          if (last_grant_q == GRANT_HOST) begin
            host_rdata_d = ram_dout;
            host_ack_d   = 1'b1;
          end else begin
            cpu_rdata_d = ram_dout;
            cpu_ack_d   = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_HOST;
      burst_cnt_q  <= BURST_MAX;
      wait_cnt_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      cpu_ack_q    <= cpu_ack_d;
      host_ack_q   <= host_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign cpu_ack    = cpu_ack_q;
  assign host_ack   = host_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign cpu_wait   = cpu_req & ~cpu_ack_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_cpu_q, stat_cpu_d, stat_host_q, stat_host_d, stat_conf_q, stat_conf_d;
  logic        idle_req;

  assign idle_req = (state_q == S_IDLE) & (cpu_req | host_req);

  always_comb begin
    stat_cpu_d  = stat_cpu_q;
    stat_host_d = stat_host_q;
    stat_conf_d = stat_conf_q;
    if (stat_clr) begin
      stat_cpu_d  = '0;
      stat_host_d = '0;
      stat_conf_d = '0;
    end else begin
      if (idle_req && !grant_host && stat_cpu_q != 16'hFFFF) stat_cpu_d = stat_cpu_q + 16'd1;
      if (idle_req && grant_host && stat_host_q != 16'hFFFF) stat_host_d = stat_host_q + 16'd1;
      if (idle_req && cpu_req && host_req && stat_conf_q != 16'hFFFF)
        stat_conf_d = stat_conf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_cpu_q  <= '0;
      stat_host_q <= '0;
      stat_conf_q <= '0;
    end else begin
      stat_cpu_q  <= stat_cpu_d;
      stat_host_q <= stat_host_d;
      stat_conf_q <= stat_conf_d;
    end
  end

  assign stat_cpu_grant  = stat_cpu_q;
  assign stat_host_grant = stat_host_q;
  assign stat_conflict   = stat_conf_q;
`endif

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed self-checking bench for data_ram_arbiter with a one-cycle-latency RAM model.
// Stats checks are compiled in when ARB_STATS_EN is defined.
module tb_data_ram_arbiter;

  logic        clk, reset;
  logic        cpu_req, cpu_we, host_req, host_we;
  logic [15:0] cpu_addr, host_addr, ram_addr;
  logic [7:0]  cpu_wdata, host_wdata, cpu_rdata, host_rdata, ram_din, ram_dout;
  logic        cpu_ack, cpu_wait, host_ack, ram_we;
`ifdef ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_cpu_grant, stat_host_grant, stat_conflict;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:65535];

  data_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
`ifdef ARB_STATS_EN
    .stat_clr(stat_clr), .stat_cpu_grant(stat_cpu_grant),
    .stat_host_grant(stat_host_grant), .stat_conflict(stat_conflict),
`endif
    .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: write and read address sampled at the same edge, data one cycle later.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    logic [42:0] outs;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cpu_req = i[0]; host_req = i[1]; cpu_we = ~i[0]; host_we = i[2];
      cpu_addr = 16'h1111 * 16'(i); host_addr = 16'hFFFF - 16'(i);
      cpu_wdata = 8'h11 * 8'(i); host_wdata = 8'hF0 ^ 8'(i);
      tick();
      outs = {cpu_ack, host_ack, ram_we, ram_addr, ram_din, cpu_rdata, host_rdata};
      tests++;
      if (outs !== 43'd0) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, outs);
      end
      tests++;
      if (cpu_wait !== cpu_req) begin
        fails++;
        $display("FAIL reset_cpu_wait cycle %0d: got %b expected %b", i, cpu_wait, cpu_req);
      end
    end
    cpu_req = 1'b0; host_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_cpu_write_read;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hA5;
    tick();
    tests++;
    if ({ram_we, ram_addr, ram_din, cpu_ack} !== {1'b1, 16'h1234, 8'hA5, 1'b0}) begin
      fails++;
      $display("FAIL wr_cycle1: we=%b addr=%h din=%h ack=%b expected 1/1234/a5/0",
               ram_we, ram_addr, ram_din, cpu_ack);
    end
    cpu_wdata = 8'h00; cpu_addr = 16'h0000;
    tick();
    tests++;
    if ({ram_we, cpu_ack, cpu_wait} !== 3'b010) begin
      fails++;
      $display("FAIL wr_cycle2: we=%b ack=%b wait=%b expected 0/1/0", ram_we, cpu_ack, cpu_wait);
    end
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    tick();
    tests++;
    if ({ram_we, ram_addr, cpu_ack, cpu_wait} !== {1'b0, 16'h1234, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL rd_cycle1: we=%b addr=%h ack=%b wait=%b expected 0/1234/0/1",
               ram_we, ram_addr, cpu_ack, cpu_wait);
    end
    tick();
    tests++;
    if (cpu_ack !== 1'b0) begin
      fails++;
      $display("FAIL rd_cycle2_ack: got %b expected 0", cpu_ack);
    end
    tick();
    tests++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, 8'hA5}) begin
      fails++;
      $display("FAIL rd_cycle3: ack=%b rdata=%h expected 1/a5", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_contention;
    int n = 0;
    logic exp_host;
    apply_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'hC0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0200; host_wdata = 8'hD0;
    for (int cyc = 0; cyc < 45 && n < 11; cyc++) begin
      tick();
      tests++;
      if (cpu_wait !== ~cpu_ack || (cpu_ack & host_ack)) begin
        fails++;
        $display("FAIL contention_wait cycle %0d: wait=%b cpu_ack=%b host_ack=%b",
                 cyc, cpu_wait, cpu_ack, host_ack);
      end
      if (cpu_ack | host_ack) begin
        exp_host = (n % 5) != 0;
        tests++;
        if (host_ack !== exp_host) begin
          fails++;
          $display("FAIL grant_order #%0d: host_ack=%b expected %b", n, host_ack, exp_host);
        end
        n++;
        if (n == 11) begin
          cpu_req = 1'b0; host_req = 1'b0;
        end
      end
    end
    tests++;
    if (n != 11) begin
      fails++;
      $display("FAIL contention_timeout: got %0d grants expected 11", n);
      cpu_req = 1'b0; host_req = 1'b0;
    end
    tick();
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats;
    tests++;
    if ({stat_cpu_grant, stat_host_grant, stat_conflict} !== {16'd3, 16'd8, 16'd11}) begin
      fails++;
      $display("FAIL stats_counts: cpu=%0d host=%0d conf=%0d expected 3/8/11",
               stat_cpu_grant, stat_host_grant, stat_conflict);
    end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    tests++;
    if ({stat_cpu_grant, stat_host_grant, stat_conflict} !== 48'd0) begin
      fails++;
      $display("FAIL stats_clear: cpu=%0d host=%0d conf=%0d expected 0",
               stat_cpu_grant, stat_host_grant, stat_conflict);
    end
  endtask
`endif

  task automatic test_back_to_back;
    int n = 0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'd0; host_wdata = 8'h50;
    for (int cyc = 1; cyc <= 40 && n < 10; cyc++) begin
      tick();
      if (host_ack) begin
        tests++;
        if (cyc != 2 + 3 * n) begin
          fails++;
          $display("FAIL b2b_ack_cycle #%0d: got cycle %0d expected %0d", n, cyc, 2 + 3 * n);
        end
        n++;
        if (n == 10) host_req = 1'b0;
        else begin
          host_addr = 16'(n); host_wdata = 8'h50 + 8'(n);
        end
      end
    end
    tests++;
    if (n != 10) begin
      fails++;
      $display("FAIL b2b_timeout: got %0d acks expected 10", n);
      host_req = 1'b0;
    end
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd5;
    repeat (3) tick();
    tests++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h55}) begin
      fails++;
      $display("FAIL b2b_cpu_read5: ack=%b rdata=%h expected 1/55", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'd9;
    repeat (3) tick();
    tests++;
    if ({host_ack, host_rdata, cpu_ack, cpu_rdata} !== {1'b1, 8'h59, 1'b0, 8'h55}) begin
      fails++;
      $display("FAIL host_read9: host_ack=%b host_rdata=%h cpu_ack=%b cpu_rdata=%h expected 1/59/0/55",
               host_ack, host_rdata, cpu_ack, cpu_rdata);
    end
    host_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0AAA; host_wdata = 8'h77;
    tick();
    tests++;
    if (ram_we !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre_we: got %b expected 1", ram_we);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({ram_we, host_ack, ram_addr} !== 18'd0) begin
      fails++;
      $display("FAIL midrst_async: we=%b ack=%b addr=%h expected 0/0/0", ram_we, host_ack, ram_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({ram_we, host_ack} !== 2'b00) begin
        fails++;
        $display("FAIL midrst_hold cycle %0d: we=%b ack=%b expected 0/0", i, ram_we, host_ack);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    host_addr = 16'h0BBB; host_wdata = 8'h3C;
    tick();
    tests++;
    if ({ram_we, ram_addr, ram_din, host_ack} !== {1'b1, 16'h0BBB, 8'h3C, 1'b0}) begin
      fails++;
      $display("FAIL midrst_restart_c1: we=%b addr=%h din=%h ack=%b expected 1/0bbb/3c/0",
               ram_we, ram_addr, ram_din, host_ack);
    end
    tick();
    tests++;
    if ({ram_we, host_ack} !== 2'b01) begin
      fails++;
      $display("FAIL midrst_restart_c2: we=%b ack=%b expected 0/1", ram_we, host_ack);
    end
    host_req = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
`ifdef ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_cpu_write_read();
    test_contention();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    test_back_to_back();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
